// File: rtl/coinc_pkg.sv
// Shared constants and helpers for the coincidence counter bank.
package coinc_pkg;

  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned N_CH_MIN = 2;
  localparam int unsigned N_CH_MAX = 6;

  // Index 0 is the tick counter and gets the wider tick width.
  function automatic int unsigned cnt_width(input int unsigned idx,
                                            input int unsigned cnt_w,
                                            input int unsigned tick_w);
    return (idx == 0) ? tick_w : cnt_w;
  endfunction

endpackage

// File: rtl/coinc_cell.sv
// One live counter with sticky overflow plus its snapshot register.
// Define COINC_SATURATE_EN for saturating counters; wrap-around otherwise.
module coinc_cell #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit_i,
  input  logic         enable_i,
  input  logic         clear_i,
  output logic [W-1:0] snap_o,
  output logic         snap_ovf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] snap_q;
  logic         snap_ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (hit_i && enable_i) begin
`ifdef COINC_SATURATE_EN
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`else
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
`endif
    end
  end

  // On clear the snapshot takes the post-increment value so the boundary cycle is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      snap_q     <= '0;
      snap_ovf_q <= 1'b0;
    end else if (clear_i) begin
      snap_q     <= cnt_d;
      snap_ovf_q <= ovf_d;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign snap_o     = snap_q;
  assign snap_ovf_o = snap_ovf_q;

endmodule

// File: rtl/coinc_counter_bank.sv
// N-channel coincidence counter bank with snapshot-on-clear and a registered read port.
// Define COINC_SATURATE_EN for saturating counters; wrap-around otherwise.
module coinc_counter_bank
  import coinc_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TICK_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   channel,
  input  logic              enable,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [N_CH-1:0]   rd_addr,
  output logic              rd_valid,
  output logic [TICK_W-1:0] rd_data,
  output logic              rd_ovf,
  output logic [SEQ_W-1:0]  rd_seq,
  output logic [SEQ_W-1:0]  snap_seq
);

  localparam int unsigned NUM = 1 << N_CH;

  logic [TICK_W-1:0] snap_w [NUM];
  logic [NUM-1:0]    ovf_w;

  for (genvar k = 0; k < NUM; k++) begin : g_cell
    localparam int unsigned W = cnt_width(k, CNT_W, TICK_W);
    logic [W-1:0] snap;
    logic         hit;

    assign hit = ((channel & N_CH'(k)) == N_CH'(k));

    coinc_cell #(.W(W)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .hit_i      (hit),
      .enable_i   (enable),
      .clear_i    (clear),
      .snap_o     (snap),
      .snap_ovf_o (ovf_w[k])
    );

    assign snap_w[k] = TICK_W'(snap);
  end

  logic              rd_valid_q;
  logic [TICK_W-1:0] rd_data_q;
  logic              rd_ovf_q;
  logic [SEQ_W-1:0]  rd_seq_q;
  logic [SEQ_W-1:0]  snap_seq_q;

  // Reads sample the snapshot before a same-cycle clear lands, returning the old window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_seq_q   <= '0;
      snap_seq_q <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= snap_w[rd_addr];
        rd_ovf_q  <= ovf_w[rd_addr];
        rd_seq_q  <= snap_seq_q;
      end
      if (clear) begin
        snap_seq_q <= snap_seq_q + 1'b1;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;
  assign rd_seq   = rd_seq_q;
  assign snap_seq = snap_seq_q;

endmodule

// File: tb/tb_coinc_counter_bank.sv
// Directed self-checking bench: default bank plus a CNT_W=4 bank for overflow behaviour.
module tb_coinc_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  channel, rd_addr;
  logic        enable, clear, rd_req;
  logic        rd_valid, rd_ovf;
  logic [47:0] rd_data;
  logic [7:0]  rd_seq, snap_seq;

  logic [3:0]  s_channel, s_rd_addr;
  logic        s_enable, s_clear, s_rd_req;
  logic        s_rd_valid, s_rd_ovf;
  logic [47:0] s_rd_data;
  logic [7:0]  s_rd_seq, s_snap_seq;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned model [16];

  always #5 clk = ~clk;

  coinc_counter_bank #(.N_CH(4), .CNT_W(32), .TICK_W(48)) u_dut (
    .clk(clk), .rst_n(rst_n), .channel(channel), .enable(enable), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ovf(rd_ovf), .rd_seq(rd_seq), .snap_seq(snap_seq)
  );

  coinc_counter_bank #(.N_CH(4), .CNT_W(4), .TICK_W(48)) u_small (
    .clk(clk), .rst_n(rst_n), .channel(s_channel), .enable(s_enable), .clear(s_clear),
    .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .rd_ovf(s_rd_ovf), .rd_seq(s_rd_seq), .snap_seq(s_snap_seq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input bit sel, input logic [3:0] a, input logic [63:0] exp_d,
                    input logic exp_ovf, input logic [7:0] exp_seq, input string tag);
    if (sel) begin
      s_rd_req = 1'b1; s_rd_addr = a;
    end else begin
      rd_req = 1'b1; rd_addr = a;
    end
    step();
    rd_req = 1'b0; s_rd_req = 1'b0;
    if (sel) begin
      check({tag, ".valid"}, 64'(s_rd_valid), 64'd1);
      check({tag, ".data"},  64'(s_rd_data),  exp_d);
      check({tag, ".ovf"},   64'(s_rd_ovf),   64'(exp_ovf));
      check({tag, ".seq"},   64'(s_rd_seq),   64'(exp_seq));
    end else begin
      check({tag, ".valid"}, 64'(rd_valid), 64'd1);
      check({tag, ".data"},  64'(rd_data),  exp_d);
      check({tag, ".ovf"},   64'(rd_ovf),   64'(exp_ovf));
      check({tag, ".seq"},   64'(rd_seq),   64'(exp_seq));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    channel = '0; enable = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_addr = '0;
    s_channel = '0; s_enable = 1'b0; s_clear = 1'b0; s_rd_req = 1'b0; s_rd_addr = '0;
    step(); step();
    check("rst.valid", 64'(rd_valid), 64'd0);
    check("rst.data",  64'(rd_data),  64'd0);
    check("rst.seq",   64'(snap_seq), 64'd0);
    rst_n = 1'b1;

    // 100 enabled cycles with channels 0,1 high; clear lands on the 100th
    enable = 1'b1; channel = 4'b0011;
    for (int i = 0; i < 99; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b0;
    check("w1.snap_seq", 64'(snap_seq), 64'd1);
    rd(0, 4'd0,  100, 0, 1, "w1.a0");
    rd(0, 4'd1,  100, 0, 1, "w1.a1");
    rd(0, 4'd2,  100, 0, 1, "w1.a2");
    rd(0, 4'd3,  100, 0, 1, "w1.a3");
    rd(0, 4'd5,  0,   0, 1, "w1.a5");
    rd(0, 4'd15, 0,   0, 1, "w1.a15");

    // read coinciding with the second clear returns the first window
    enable = 1'b1; channel = 4'b0000;
    for (int i = 0; i < 7; i++) step();
    clear = 1'b1; rd_req = 1'b1; rd_addr = 4'd0;
    step();
    clear = 1'b0; rd_req = 1'b0; enable = 1'b0;
    check("w2.same.valid", 64'(rd_valid), 64'd1);
    check("w2.same.data",  64'(rd_data),  64'd100);
    check("w2.same.seq",   64'(rd_seq),   64'd1);
    check("w2.snap_seq",   64'(snap_seq), 64'd2);
    rd(0, 4'd0, 8, 0, 2, "w2.a0");
    rd(0, 4'd3, 0, 0, 2, "w2.a3");
    step();
    check("idle.valid", 64'(rd_valid), 64'd0);

    // clear with enable low: live values pass through unchanged (zero here)
    clear = 1'b1;
    step();
    clear = 1'b0;
    rd(0, 4'd0, 0, 0, 3, "w3.a0");

    // clear held three cycles: each is its own one-cycle window
    enable = 1'b1; channel = 4'b1111; clear = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clear = 1'b0; enable = 1'b0;
    check("hold.snap_seq", 64'(snap_seq), 64'd6);
    rd(0, 4'd0,  1, 0, 6, "hold.a0");
    rd(0, 4'd15, 1, 0, 6, "hold.a15");

    // mixed pattern window against a bench model
    for (int k = 0; k < 16; k++) model[k] = 0;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ch;
      ch = 4'((i * 7 + i / 5) % 16);
      enable = (i % 4) != 3;
      channel = ch;
      if (enable)
        for (int k = 0; k < 16; k++)
          if ((ch & 4'(k)) == 4'(k)) model[k]++;
      step();
    end
    enable = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 16; k++)
      rd(0, 4'(k), 64'(model[k]), 0, 7, $sformatf("model.a%0d", k));

    // narrow counters: 20 all-high cycles on a 4-bit counter
    s_enable = 1'b1; s_channel = 4'b1111;
    for (int i = 0; i < 19; i++) step();
    s_clear = 1'b1;
    step();
    s_clear = 1'b0; s_enable = 1'b0;
`ifdef COINC_SATURATE_EN
    rd(1, 4'd15, 15, 1, 1, "ovf.a15");
    rd(1, 4'd3,  15, 1, 1, "ovf.a3");
`else
    rd(1, 4'd15, 4, 1, 1, "ovf.a15");
    rd(1, 4'd3,  4, 1, 1, "ovf.a3");
`endif
    rd(1, 4'd0, 20, 0, 1, "ovf.a0");

    // reset mid-window with a read request pending
    enable = 1'b1; channel = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    rd_req = 1'b1; rd_addr = 4'd0; rst_n = 1'b0;
    step();
    rd_req = 1'b0; rst_n = 1'b1; enable = 1'b0;
    check("rstp.valid",    64'(rd_valid), 64'd0);
    check("rstp.data",     64'(rd_data),  64'd0);
    check("rstp.seq",      64'(rd_seq),   64'd0);
    check("rstp.snap_seq", 64'(snap_seq), 64'd0);
    rd(0, 4'd0,  0, 0, 0, "rstp.a0");
    rd(0, 4'd15, 0, 0, 0, "rstp.a15");
    rd(1, 4'd15, 0, 0, 0, "rstp.s15");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coinc_counter_bank.md
# coinc_counter_bank

Parametrised N-channel coincidence counter bank: for every non-empty subset of input channels it counts the clock cycles in which all channels of that subset are asserted, alongside a cycle-tick counter for the live window. A synchronous `clear` closes the window into a shadow snapshot bank without losing a cycle. Software reads the snapshot one word at a time through an addressed request/valid port instead of a flat wide bus. It sits between the channel synchronisers and the readout/host interface logic.

## Interface
- `N_CH`, 4, number of input channels (2..6); bank holds 2^N_CH counters
- `CNT_W`, 32, width of each coincidence counter
- `TICK_W`, 48, width of the tick counter (index 0); must be >= CNT_W
- `clk` in 1, single clock; all logic on rising edge
- `rst_n` in 1, synchronous, active-low reset
- `channel` in N_CH, per-cycle channel hit flags (already synchronised)
- `enable` in 1, count qualifier; no counter advances while low
- `clear` in 1, one-cycle pulse: snapshot live bank, restart live bank
- `rd_req` in 1, read request pulse
- `rd_addr` in N_CH, counter index to read (0 = ticks, k = subset mask k)
- `rd_valid` out 1, rd_data/rd_ovf/rd_seq valid this cycle
- `rd_data` out TICK_W, snapshot value, zero-extended for k != 0
- `rd_ovf` out 1, snapshot overflow flag of the addressed counter
- `rd_seq` out 8, snapshot sequence number the read was served from
- `snap_seq` out 8, current snapshot sequence number (wraps 255 -> 0)

## Operation
- Index 0: tick counter, increments every cycle `enable`=1.
- Index k (1..2^N_CH-1): increments when `enable`=1 and `(channel & k) == k`.
- All counters sampled in parallel each cycle; one increment max per counter per cycle.
- `clear`=1: snapshot[k] <= live[k] + this cycle's increment; snapshot ovf[k] <= live ovf[k] including this cycle's overflow; live[k] and live ovf <= 0; `snap_seq` += 1. No sample is lost or double counted across the boundary.
- `clear`=0: live counters update normally; snapshot bank holds.
- Overflow: live ovf[k] sticky-set when counter k would exceed 2^W-1 (W = TICK_W for k=0, else CNT_W); counting behaviour at overflow per Configuration.
- Read: `rd_req`=1 at cycle t -> at t+1 `rd_valid`=1 with snapshot[rd_addr], ovf, and `rd_seq` = `snap_seq` as of cycle t. Back-to-back requests allowed, one result per request, in order. `rd_valid` low otherwise.
- All addresses 0..2^N_CH-1 valid; no error path.

## Timing
- Reset (`rst_n`=0 at edge): all live, snapshot, ovf cleared; `rd_valid`=0, `rd_data`=0, `rd_ovf`=0, `rd_seq`=0, `snap_seq`=0. Reset overrides `clear` and `rd_req` in same cycle; pending read dropped.
- Read latency 1 cycle, registered outputs.
- `rd_req` and `clear` in same cycle: read returns the OLD snapshot, `rd_seq` = old `snap_seq`.
- `clear` held high for consecutive cycles: each cycle is a 1-cycle window; snapshot holds that cycle's sample only.
- `clear` with `enable`=0: snapshot gets live values unchanged; live zeroed.

## Configuration
- `COINC_SATURATE_EN` defined: counters saturate at all-ones and hold until clear/reset; ovf sets on first blocked increment.
- Not defined: counters wrap modulo 2^W; ovf sets on wrap and stays set until clear/reset.

## Structure
- Package `coinc_pkg`: `SEQ_W`=8 constant, N_CH range limits, function returning counter width for an index (TICK_W for 0, else CNT_W).
- Sub-module `coinc_cell`: one live counter + ovf + snapshot register, parameterised width, inputs hit/clear/enable; bank instantiates 2^N_CH cells via generate and a registered read mux.

## Test plan
- Reset then `enable`=1 for 100 cycles, `channel`=4'b0011, `clear` at cycle 100 -> read addr 0 = 100, addr 1 = 100, addr 2 = 100, addr 3 = 100, addr 5 = 0, `rd_seq`=1.
- Random `channel` 10000 cycles, `enable` toggling, periodic `clear` -> every snapshot word equals scoreboard subset count; sum across windows equals total (no lost boundary samples).
- CNT_W=4, `channel`=4'b1111 for 20 cycles, `clear` -> addr 15 reads 15 with ovf=1 when `COINC_SATURATE_EN`, reads 4 with ovf=1 otherwise.
- `rd_req` addr 0 in same cycle as second `clear` -> returns first window's tick count, `rd_seq`=1; next read returns second window, `rd_seq`=2.
- `rst_n` low mid-window with `rd_req` pending -> next cycle `rd_valid`=0, all reads return 0, `snap_seq`=0.
- N_CH=2 and N_CH=6 builds: addr 2^N_CH-1 counts all-channels-high cycles exactly.
